// File: rtl/pe_psum_packetizer.sv
// PE psum packetizer: 3-lane dot product per ifmap word, accumulated into psum NoC packets.
// Optional `PE_PSUM_SAT_EN: accumulator saturates at all-ones instead of wrapping.
module pe_psum_packetizer #(
    parameter int unsigned ACC_LEN    = 5,
    parameter int unsigned FILT_REUSE = 3,
    parameter int unsigned PSUM_WIDTH = 24,
    parameter logic [3:0]  DEST_ADDR  = 4'b0011,
    parameter logic [3:0]  SRC_ADDR   = 4'b1101
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] i_filter_data,
    input  logic        i_filter_valid,
    output logic        o_filter_ready,
    input  logic [23:0] i_ifmap_data,
    input  logic        i_ifmap_valid,
    output logic        o_ifmap_ready,
    output logic [32:0] o_pkt_out,
    output logic        o_pkt_valid,
    input  logic        i_pkt_ready
);

    // state      | meaning
    // FILT_WAIT  | waiting for a filter word; weights and counters cleared on load
    // ACCUM      | accepting one ifmap word per cycle into acc
    // EMIT       | offering the finished psum packet, inputs stalled
    localparam logic [1:0] S_FILT_WAIT = 2'd0;
    localparam logic [1:0] S_ACCUM     = 2'd1;
    localparam logic [1:0] S_EMIT      = 2'd2;

    localparam logic [3:0] ACC_LAST   = 4'(ACC_LEN - 1);
    localparam logic [3:0] REUSE_LAST = 4'(FILT_REUSE - 1);

    logic [1:0]            r_state;
    logic [7:0]            r_w0;
    logic [7:0]            r_w1;
    logic [7:0]            r_w2;
    logic [PSUM_WIDTH-1:0] r_acc;
    logic [3:0]            r_wcnt;
    logic [3:0]            r_rcnt;

    logic [15:0]           w_p0;
    logic [15:0]           w_p1;
    logic [15:0]           w_p2;
    logic [17:0]           w_dot;
    logic [PSUM_WIDTH-1:0] w_acc_next;

    assign w_p0  = 16'(r_w0) * 16'(i_ifmap_data[7:0]);
    assign w_p1  = 16'(r_w1) * 16'(i_ifmap_data[15:8]);
    assign w_p2  = 16'(r_w2) * 16'(i_ifmap_data[23:16]);
    assign w_dot = 18'(w_p0) + 18'(w_p1) + 18'(w_p2);

`ifdef PE_PSUM_SAT_EN
    // Sum kept one bit wider than any acc+dot can reach, so overflow is visible before clamping.
    localparam logic [24:0] ACC_MAX = (25'd1 << PSUM_WIDTH) - 25'd1;
    logic [24:0] w_sum;
    assign w_sum      = 25'(r_acc) + 25'(w_dot);
    assign w_acc_next = (w_sum > ACC_MAX) ? {PSUM_WIDTH{1'b1}} : w_sum[PSUM_WIDTH-1:0];
`else
    logic [PSUM_WIDTH-1:0] w_dot_ext;
    assign w_dot_ext  = PSUM_WIDTH'(w_dot);
    assign w_acc_next = r_acc + w_dot_ext;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILT_WAIT;
            r_w0    <= '0;
            r_w1    <= '0;
            r_w2    <= '0;
            r_acc   <= '0;
            r_wcnt  <= '0;
            r_rcnt  <= '0;
        end else begin
            case (r_state)
                S_FILT_WAIT: begin
                    if (i_filter_valid) begin
                        r_w0    <= i_filter_data[7:0];
                        r_w1    <= i_filter_data[15:8];
                        r_w2    <= i_filter_data[23:16];
                        r_acc   <= '0;
                        r_wcnt  <= '0;
                        r_rcnt  <= '0;
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (i_ifmap_valid) begin
                        r_acc  <= w_acc_next;
                        r_wcnt <= r_wcnt + 4'd1;
                        if (r_wcnt == ACC_LAST) begin
                            r_state <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    if (i_pkt_ready) begin
                        r_rcnt <= r_rcnt + 4'd1;
                        if (r_rcnt == REUSE_LAST) begin
                            r_state <= S_FILT_WAIT;
                        end else begin
                            r_acc   <= '0;
                            r_wcnt  <= '0;
                            r_state <= S_ACCUM;
                        end
                    end
                end
                default: r_state <= S_FILT_WAIT;
            endcase
        end
    end

    // Readies and valid decode from state alone; the packet bus reads zero outside EMIT.
    assign o_filter_ready = (r_state == S_FILT_WAIT);
    assign o_ifmap_ready  = (r_state == S_ACCUM);
    assign o_pkt_valid    = (r_state == S_EMIT);
    assign o_pkt_out      = o_pkt_valid ? {1'b0, DEST_ADDR, SRC_ADDR, 24'(r_acc)} : 33'd0;

endmodule
